// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar types: burst encodings, AR request payload and the
// per-burst record kept while read data is outstanding.
package axi_xbar_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_LEN_W  = 4;
  localparam int AXI_SIZE_W = 3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_SIZE_W-1:0] size;
    logic [1:0]            burst;
  } ar_req_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]  id;
    logic [AXI_LEN_W-1:0] len;
  } track_entry_t;

endpackage

// File: rtl/rd_track_fifo.sv
// In-order record of issued read bursts awaiting their R beats.
// Head is read combinationally so the current beat can be checked in-cycle.
module rd_track_fifo
  import axi_xbar_pkg::*;
#(
  parameter type entry_t = track_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ar_issue_ctrl.sv
// Issues AR requests from the pending FIFO with a bound on outstanding bursts,
// and checks returning R beats against the issued ID/length in order.
module ar_issue_ctrl
  import axi_xbar_pkg::*;
#(
  parameter int ID_WIDTH        = AXI_ID_W,
  parameter int ADDR_WIDTH      = AXI_ADDR_W,
  parameter int LEN_WIDTH       = AXI_LEN_W,
  parameter int SIZE_WIDTH      = AXI_SIZE_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESETn,
  input  logic                               fifo_empty,
  output logic                               fifo_pop,
  input  logic [ID_WIDTH-1:0]                front_ARID,
  input  logic [ADDR_WIDTH-1:0]              front_ARADDR,
  input  logic [LEN_WIDTH-1:0]               front_ARLEN,
  input  logic [SIZE_WIDTH-1:0]              front_ARSIZE,
  input  logic [1:0]                         front_ARBURST,
  output logic [ID_WIDTH-1:0]                ARID_M,
  output logic [ADDR_WIDTH-1:0]              ARADDR_M,
  output logic [LEN_WIDTH-1:0]               ARLEN_M,
  output logic [SIZE_WIDTH-1:0]              ARSIZE_M,
  output logic [1:0]                         ARBURST_M,
  output logic                               ARVALID_M,
  input  logic                               ARREADY_M,
  input  logic [ID_WIDTH-1:0]                RID_M,
  input  logic                               RLAST_M,
  input  logic                               RVALID_M,
  input  logic                               RREADY_M,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               busy,
  output logic                               rlast_err,
  output logic                               rid_err
);

  localparam int               CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W:0]   LIMIT    = (CNT_W + 1)'(MAX_OUTSTANDING);
  localparam logic [0:0]       ST_EMPTY = 1'b0;
  localparam logic [0:0]       ST_VALID = 1'b1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]  id;
    logic [LEN_WIDTH-1:0] len;
  } trk_t;

  logic [0:0]           state;
  logic                 slot_free;
  logic                 ar_hs;
  logic [CNT_W:0]       inflight;
  logic                 r_beat;
  logic                 trk_empty;
  logic                 trk_pop;
  logic                 expected_last;
  logic [LEN_WIDTH-1:0] beat_cnt;
  trk_t                 trk_din;
  trk_t                 trk_head;

  assign ARVALID_M = (state == ST_VALID);
  assign ar_hs     = ARVALID_M & ARREADY_M;
  assign slot_free = ~ARVALID_M | ARREADY_M;

  // A pending ARVALID is charged against the limit even if it handshakes now.
  assign inflight  = {1'b0, outstanding} + {{CNT_W{1'b0}}, ARVALID_M};
  assign fifo_pop  = ~fifo_empty & slot_free & (inflight < LIMIT);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= ST_EMPTY;
      ARID_M    <= '0;
      ARADDR_M  <= '0;
      ARLEN_M   <= '0;
      ARSIZE_M  <= '0;
      ARBURST_M <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (fifo_pop) state <= ST_VALID;
        ST_VALID: if (ar_hs && !fifo_pop) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
      if (fifo_pop) begin
        ARID_M    <= front_ARID;
        ARADDR_M  <= front_ARADDR;
        ARLEN_M   <= front_ARLEN;
        ARSIZE_M  <= front_ARSIZE;
        ARBURST_M <= front_ARBURST;
      end
    end
  end

  assign trk_din.id  = ARID_M;
  assign trk_din.len = ARLEN_M;

  rd_track_fifo #(
    .entry_t (trk_t),
    .DEPTH   (MAX_OUTSTANDING)
  ) u_track (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (ar_hs),
    .din   (trk_din),
    .pop   (trk_pop),
    .head  (trk_head),
    .count (outstanding)
  );

  assign r_beat        = RVALID_M & RREADY_M;
  assign trk_empty     = (outstanding == '0);
  assign expected_last = (beat_cnt == trk_head.len);
  // Either an early RLAST or reaching the expected count closes the burst.
  assign trk_pop       = r_beat & ~trk_empty & (RLAST_M | expected_last);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beat_cnt  <= '0;
      rlast_err <= 1'b0;
      rid_err   <= 1'b0;
    end else begin
      rlast_err <= 1'b0;
      rid_err   <= 1'b0;
      if (r_beat) begin
        if (trk_empty) begin
          rid_err <= 1'b1;
        end else begin
          rlast_err <= (RLAST_M != expected_last);
          rid_err   <= (RID_M != trk_head.id);
          if (trk_pop) beat_cnt <= '0;
          else         beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = ARVALID_M | ~trk_empty;

endmodule

// File: tb/tb_ar_issue_ctrl.sv
// Directed bench for ar_issue_ctrl: a model upstream FIFO feeds the DUT, popped
// entries go to a scoreboard checked at each AR handshake; error pulses are
// checked every cycle against per-beat expectations.
module tb_ar_issue_ctrl;
  import axi_xbar_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [3:0]  front_ARID;
  logic [31:0] front_ARADDR;
  logic [3:0]  front_ARLEN;
  logic [2:0]  front_ARSIZE;
  logic [1:0]  front_ARBURST;
  logic [3:0]  ARID_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic        ARVALID_M;
  logic        ARREADY_M;
  logic [3:0]  RID_M;
  logic        RLAST_M;
  logic        RVALID_M;
  logic        RREADY_M;
  logic [2:0]  outstanding;
  logic        busy;
  logic        rlast_err;
  logic        rid_err;

  ar_issue_ctrl #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(4), .SIZE_WIDTH(3), .MAX_OUTSTANDING(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .front_ARID(front_ARID), .front_ARADDR(front_ARADDR), .front_ARLEN(front_ARLEN),
    .front_ARSIZE(front_ARSIZE), .front_ARBURST(front_ARBURST),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
    .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M),
    .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RLAST_M(RLAST_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .outstanding(outstanding), .busy(busy), .rlast_err(rlast_err), .rid_err(rid_err)
  );

  always #5 ACLK = ~ACLK;

  ar_req_t src_q[$];
  ar_req_t exp_q[$];
  int      vecs = 0;
  int      errs = 0;
  int      pop_cnt = 0;
  int      hs_cnt = 0;
  int      pop0, hs0;
  logic    err_exp_rlast = 1'b0, err_exp_rid = 1'b0;
  logic    pend_rlast = 1'b0, pend_rid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ar_req_t mk(input logic [3:0] id, input logic [31:0] addr,
                                 input logic [3:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
    ar_req_t r;
    r.id = id; r.addr = addr; r.len = len; r.size = size; r.burst = burst;
    return r;
  endfunction

  task automatic drive_front();
    fifo_empty = (src_q.size() == 0);
    if (src_q.size() != 0) begin
      front_ARID    = src_q[0].id;
      front_ARADDR  = src_q[0].addr;
      front_ARLEN   = src_q[0].len;
      front_ARSIZE  = src_q[0].size;
      front_ARBURST = src_q[0].burst;
    end else begin
      front_ARID = '0; front_ARADDR = '0; front_ARLEN = '0;
      front_ARSIZE = '0; front_ARBURST = '0;
    end
    #1;
  endtask

  // One clock: sample at negedge, update the models, drive new inputs after posedge.
  task automatic tick();
    ar_req_t r;
    logic    pop_s, hs_s;
    @(negedge ACLK);
    pop_s = fifo_pop;
    hs_s  = ARVALID_M & ARREADY_M;
    chk("rlast_err", rlast_err, err_exp_rlast);
    chk("rid_err", rid_err, err_exp_rid);
    if (hs_s) begin
      hs_cnt++;
      vecs++;
      assert (exp_q.size() != 0) else begin
        errs++;
        $error("FAIL ar_unexpected observed=handshake expected=none id=%0h", ARID_M);
      end
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("ar_id", ARID_M, r.id);
        chk("ar_addr", ARADDR_M, r.addr);
        chk("ar_len", ARLEN_M, r.len);
        chk("ar_size", ARSIZE_M, r.size);
        chk("ar_burst", ARBURST_M, r.burst);
        $display("AR  id=%0h addr=%08h len=%0d", ARID_M, ARADDR_M, ARLEN_M);
      end
    end
    if (pop_s && src_q.size() != 0) begin
      pop_cnt++;
      exp_q.push_back(src_q.pop_front());
    end
    @(posedge ACLK);
    #1;
    err_exp_rlast = pend_rlast;
    err_exp_rid   = pend_rid;
    pend_rlast    = 1'b0;
    pend_rid      = 1'b0;
    drive_front();
  endtask

  task automatic beat(input logic [3:0] id, input logic last,
                      input logic e_rlast, input logic e_rid);
    RVALID_M   = 1'b1;
    RID_M      = id;
    RLAST_M    = last;
    pend_rlast = e_rlast;
    pend_rid   = e_rid;
    tick();
    $display("R   id=%0h last=%0b", id, last);
    RVALID_M = 1'b0;
    RLAST_M  = 1'b0;
  endtask

  initial begin
    ARREADY_M = 1'b0;
    RVALID_M  = 1'b0;
    RREADY_M  = 1'b1;
    RID_M     = '0;
    RLAST_M   = 1'b0;
    drive_front();

    // Reset state
    @(posedge ACLK); #1;
    chk("rst_arvalid", ARVALID_M, 0);
    chk("rst_araddr", ARADDR_M, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_pop", fifo_pop, 0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    tick();

    // Single burst
    ARREADY_M = 1'b1;
    src_q.push_back(mk(4'd3, 32'h1000, 4'd3, 3'd2, BURST_INCR));
    drive_front();
    chk("t1_pop_comb", fifo_pop, 1);
    pop0 = pop_cnt; hs0 = hs_cnt;
    tick();
    chk("t1_arvalid", ARVALID_M, 1);
    chk("t1_busy", busy, 1);
    chk("t1_out0", outstanding, 0);
    chk("t1_pop_after", fifo_pop, 0);
    tick();
    chk("t1_arvalid_drop", ARVALID_M, 0);
    chk("t1_out1", outstanding, 1);
    beat(4'd3, 1'b0, 1'b0, 1'b0);
    beat(4'd3, 1'b0, 1'b0, 1'b0);
    chk("t1_out_mid", outstanding, 1);
    beat(4'd3, 1'b0, 1'b0, 1'b0);
    beat(4'd3, 1'b1, 1'b0, 1'b0);
    chk("t1_out_done", outstanding, 0);
    chk("t1_busy_done", busy, 0);
    tick();
    chk("t1_pops", pop_cnt - pop0, 1);
    chk("t1_hs", hs_cnt - hs0, 1);

    // Backpressure
    ARREADY_M = 1'b0;
    src_q.push_back(mk(4'd1, 32'h2000, 4'd0, 3'd3, BURST_FIXED));
    src_q.push_back(mk(4'd2, 32'h3000, 4'd0, 3'd1, BURST_WRAP));
    drive_front();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", ARVALID_M, 1);
      chk("t2_hold_addr", ARADDR_M, 32'h2000);
      chk("t2_hold_id", ARID_M, 1);
      chk("t2_hold_pop", fifo_pop, 0);
      tick();
    end
    ARREADY_M = 1'b1;
    drive_front();
    chk("t2_b2b_pop", fifo_pop, 1);
    tick();
    chk("t2_b2b_valid", ARVALID_M, 1);
    chk("t2_b2b_id", ARID_M, 2);
    chk("t2_out1", outstanding, 1);
    tick();
    chk("t2_valid_drop", ARVALID_M, 0);
    chk("t2_out2", outstanding, 2);
    beat(4'd1, 1'b1, 1'b0, 1'b0);
    beat(4'd2, 1'b1, 1'b0, 1'b0);
    chk("t2_out_done", outstanding, 0);

    // Outstanding limit
    for (int i = 0; i < 6; i++)
      src_q.push_back(mk(4'(i), 32'h1_0000 + 32'(i) * 32'h40, 4'd0, 3'd2, BURST_INCR));
    drive_front();
    hs0 = hs_cnt;
    repeat (8) tick();
    chk("t3_hs4", hs_cnt - hs0, 4);
    chk("t3_pop_blocked", fifo_pop, 0);
    chk("t3_out4", outstanding, 4);
    chk("t3_valid0", ARVALID_M, 0);
    chk("t3_src_left", src_q.size(), 2);
    beat(4'd0, 1'b1, 1'b0, 1'b0);
    chk("t3_out3", outstanding, 3);
    chk("t3_pop_resume", fifo_pop, 1);
    tick();
    chk("t3_fifth_valid", ARVALID_M, 1);
    chk("t3_fifth_id", ARID_M, 4);
    for (int i = 1; i < 6; i++) beat(4'(i), 1'b1, 1'b0, 1'b0);
    chk("t3_out_done", outstanding, 0);
    chk("t3_src_empty", src_q.size(), 0);
    chk("t3_exp_empty", exp_q.size(), 0);

    // RLAST errors: early RLAST, then missing RLAST
    src_q.push_back(mk(4'd6, 32'h4000, 4'd1, 3'd2, BURST_INCR));
    drive_front();
    tick(); tick();
    chk("t4_out1", outstanding, 1);
    beat(4'd6, 1'b1, 1'b1, 1'b0);
    chk("t4_early_pop", outstanding, 0);
    src_q.push_back(mk(4'd7, 32'h5000, 4'd2, 3'd2, BURST_INCR));
    drive_front();
    tick(); tick();
    beat(4'd7, 1'b0, 1'b0, 1'b0);
    beat(4'd7, 1'b0, 1'b0, 1'b0);
    chk("t4_mid_out", outstanding, 1);
    beat(4'd7, 1'b0, 1'b1, 1'b0);
    chk("t4_missing_pop", outstanding, 0);
    tick();

    // RID mismatch and orphan beat
    src_q.push_back(mk(4'd3, 32'h6000, 4'd0, 3'd2, BURST_INCR));
    drive_front();
    tick(); tick();
    beat(4'd5, 1'b1, 1'b0, 1'b1);
    chk("t5_out0", outstanding, 0);
    beat(4'd0, 1'b1, 1'b0, 1'b1);
    chk("t5_orphan_out", outstanding, 0);
    tick();

    // Async reset mid-burst
    src_q.push_back(mk(4'd1, 32'h7000, 4'd3, 3'd2, BURST_INCR));
    src_q.push_back(mk(4'd2, 32'h8000, 4'd3, 3'd2, BURST_INCR));
    drive_front();
    tick(); tick(); tick();
    beat(4'd1, 1'b0, 1'b0, 1'b0);
    chk("t6_out2", outstanding, 2);
    ARESETn = 1'b0;
    #1;
    chk("t6_rst_valid", ARVALID_M, 0);
    chk("t6_rst_addr", ARADDR_M, 0);
    chk("t6_rst_id", ARID_M, 0);
    chk("t6_rst_len", ARLEN_M, 0);
    chk("t6_rst_out", outstanding, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rlast", rlast_err, 0);
    chk("t6_rst_rid", rid_err, 0);
    src_q.delete();
    exp_q.delete();
    err_exp_rlast = 1'b0; err_exp_rid = 1'b0;
    pend_rlast = 1'b0; pend_rid = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    drive_front();
    tick();
    src_q.push_back(mk(4'd9, 32'h9000, 4'd1, 3'd2, BURST_INCR));
    drive_front();
    tick(); tick();
    chk("t6_fresh_out", outstanding, 1);
    beat(4'd9, 1'b0, 1'b0, 1'b0);
    beat(4'd9, 1'b1, 1'b0, 1'b0);
    chk("t6_fresh_done", outstanding, 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ar_issue_ctrl.md
Name: ar_issue_ctrl

Overview:
- Downstream stage of the per-master AR pending FIFO: pops the FIFO front, drives a registered AR channel towards the crossbar/slave with VALID/READY, and bounds outstanding read bursts.
- Monitors the returning R channel, counts beats per burst against the issued ARLEN/ARID, and flags protocol errors.
- R data returns in issue order; this block does not reorder.

Parameters:
- ID_WIDTH, 4, AXI ID width.
- ADDR_WIDTH, 32, address width.
- LEN_WIDTH, 4, burst length field width (beats = ARLEN+1).
- SIZE_WIDTH, 3, burst size width.
- MAX_OUTSTANDING, 4, maximum issued-but-incomplete bursts (power of two, >=2).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- fifo_empty  in  1  AR FIFO empty.
- fifo_pop  out  1  AR FIFO pop, combinational.
- front_ARID / front_ARADDR / front_ARLEN / front_ARSIZE / front_ARBURST  in  ID_WIDTH / ADDR_WIDTH / LEN_WIDTH / SIZE_WIDTH / 2  AR FIFO head contents.
- ARID_M / ARADDR_M / ARLEN_M / ARSIZE_M / ARBURST_M  out  same widths  registered AR payload.
- ARVALID_M  out  1  AR valid.
- ARREADY_M  in  1  AR ready.
- RID_M  in  ID_WIDTH  returning read ID.
- RLAST_M  in  1  returning last flag.
- RVALID_M / RREADY_M  in  1 / 1  R handshake, observed only.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  bursts in tracker.
- busy  out  1  ARVALID_M | (outstanding!=0).
- rlast_err  out  1  one-cycle pulse on RLAST mismatch.
- rid_err  out  1  one-cycle pulse on RID mismatch or orphan beat.

Behaviour:
- Reset (async assert, sync release): all AR payload regs 0, ARVALID_M=0, tracker empty, beat_cnt=0, outstanding=0, busy=0, both error outputs 0. Reset mid-burst discards all state; there is no drain.
- Issue slot free = ~ARVALID_M | ARREADY_M.
- fifo_pop = ~fifo_empty & slot_free & (outstanding + ARVALID_M < MAX_OUTSTANDING).
- ARVALID_M counts against the limit whether or not it handshakes this cycle (conservative).
- Pop edge: payload regs <= front_*, ARVALID_M <= 1. Latency from FIFO head to ARVALID_M is 1 cycle.
- Handshake without pop: ARVALID_M <= 0. While ARVALID_M=1 and ARREADY_M=0, the payload is held stable.
- Back-to-back: a handshake and a pop in the same cycle keep ARVALID_M=1 with the new payload. Sustained issue rate is 1 burst/cycle.
- AR handshake (ARVALID_M & ARREADY_M): push {ARID_M, ARLEN_M} into the tracker FIFO.
- R beat = RVALID_M & RREADY_M. On each beat, against the tracker head {hid, hlen}:
  - expected_last = (beat_cnt == hlen).
  - RLAST_M != expected_last -> rlast_err.
  - RID_M != hid -> rid_err.
- Burst completes when RLAST_M | expected_last. On completion: pop tracker, beat_cnt <= 0. Otherwise beat_cnt <= beat_cnt+1.
  - An early RLAST terminates the burst.
  - A missing RLAST terminates the burst at the expected beat.
- Beat with empty tracker (including the same cycle as the first AR handshake): rid_err pulse, beat ignored, no state change.
- Tracker push and pop in the same cycle leave outstanding unchanged. The tracker can never overflow because of the issue gate.
- Width rules:
  - beat_cnt is LEN_WIDTH bits and never wraps past hlen.
  - outstanding is one bit wider than the tracker pointers so it can represent MAX_OUTSTANDING.
- Error pulses are registered (1-cycle delay after the offending beat) and are not sticky.
- Issue FSM: EMPTY (ARVALID_M=0) -> VALID on pop; VALID -> VALID on handshake+pop, or on stall (no handshake); VALID -> EMPTY on handshake without pop.

Decomposition:
- Shared package axi_xbar_pkg: AXI burst type constants (FIXED=2'b00, INCR=2'b01, WRAP=2'b10); struct ar_req_t {id, addr, len, size, burst} parameterised via package localparams; track_entry_t {id, len}.
- Sub-module rd_track_fifo: synchronous FIFO of track_entry_t, depth MAX_OUTSTANDING, with push/pop/count/head. Pointers wrap modulo depth; count is one bit wider.

Test Plan:
- Single burst: FIFO head {ID=3, ADDR=0x1000, LEN=3}, ARREADY_M=1, four R beats with RLAST on the 4th -> fifo_pop 1 cycle, ARVALID_M 1 cycle, outstanding 0->1->0, no errors.
- Backpressure: ARREADY_M=0 for 5 cycles -> ARVALID_M held, payload stable, fifo_pop=0; ARREADY_M=1 -> handshake, next head popped the same cycle.
- Outstanding limit: 6 queued bursts, no R traffic -> exactly 4 AR handshakes, fifo_pop stays 0, outstanding=4; one burst completes -> 5th issued within 2 cycles.
- RLAST errors: LEN=1 burst with RLAST on beat 0 -> rlast_err pulse, tracker popped; LEN=2 with no RLAST -> rlast_err on beat 2, tracker popped.
- ID/orphan: R beat with RID=5 vs head ID=3 -> rid_err; R beat with tracker empty -> rid_err, outstanding stays 0.
- Async reset asserted with outstanding=2 mid-burst -> all outputs 0 immediately; after release, a fresh burst completes cleanly.
